// File: rtl/proc_ctrl.sv
// proc_ctrl: step-sequenced control unit for a small register-transfer
// processor. Decodes mv, mvi, add and sub into bus-source selects and load
// enables over the T0..T3 step states.
// Optional feature: define PROC_CTRL_MVNZ_EN to enable mvnz (opcode 100),
// a conditional move gated by the Gnz flag.
// Widths come from REG_NUM / CMD_LENGTH (defaults 4 and 9).

`ifndef REG_NUM
`define REG_NUM 4
`endif
`ifndef CMD_LENGTH
`define CMD_LENGTH 9
`endif

module proc_ctrl (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Run,
  input  logic [`CMD_LENGTH-1:0] DIN,
  input  logic                   Gnz,
  output logic [`REG_NUM-1:0]    Rout,
  output logic                   Gout,
  output logic                   DINout,
  output logic [`REG_NUM-1:0]    Rin,
  output logic                   Ain,
  output logic                   Gin,
  output logic                   AddSub,
  output logic                   Done
);

  typedef enum logic [1:0] {
    S_T0 = 2'd0,
    S_T1 = 2'd1,
    S_T2 = 2'd2,
    S_T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef PROC_CTRL_MVNZ_EN
  localparam logic [2:0] OP_MVNZ = 3'b100;
`endif

  state_t                   state_reg, state_next;
  logic [`CMD_LENGTH-1:0]   ir_reg, ir_next;

  logic [2:0]               ir_op, ir_x, ir_y;
  logic [`REG_NUM-1:0]      x_sel, y_sel;
  logic                     regs_ok;

  assign ir_op = ir_reg[8:6];
  assign ir_x  = ir_reg[5:3];
  assign ir_y  = ir_reg[2:0];

  // Register fields beyond the register file make the instruction a no-op.
  assign regs_ok = (int'(ir_x) < `REG_NUM) && (int'(ir_y) < `REG_NUM);

  // One-hot register selects; R0 sits in the most significant bit.
  genvar gi;
  generate
    for (gi = 0; gi < `REG_NUM; gi++) begin : g_sel
      assign x_sel[`REG_NUM-1-gi] = (ir_x == 3'(gi));
      assign y_sel[`REG_NUM-1-gi] = (ir_y == 3'(gi));
    end
  endgenerate

`ifndef PROC_CTRL_MVNZ_EN
  // Gnz only matters for mvnz; keep the port without a dangling input.
  logic unused_gnz;
  assign unused_gnz = Gnz;
`endif

  // State and instruction register; reset aborts any instruction in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= S_T0;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
    end
  end

  // Next-step sequencing and output decode; outputs held low while in reset.
  always_comb begin
    state_next = state_reg;
    ir_next    = ir_reg;
    Rout       = '0;
    Gout       = 1'b0;
    DINout     = 1'b0;
    Rin        = '0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    AddSub     = 1'b0;
    Done       = 1'b0;

    if (!Reset) begin
      case (state_reg)
        S_T0: begin
          if (Run) begin
            ir_next    = DIN;
            state_next = S_T1;
          end
        end

        S_T1: begin
          // Single-step instructions and illegal words finish here.
          state_next = S_T0;
          Done       = 1'b1;
          if (regs_ok) begin
            case (ir_op)
              OP_MV: begin
                Rout = y_sel;
                Rin  = x_sel;
              end
              OP_MVI: begin
                DINout = 1'b1;
                Rin    = x_sel;
              end
              OP_ADD, OP_SUB: begin
                Rout       = x_sel;
                Ain        = 1'b1;
                Done       = 1'b0;
                state_next = S_T2;
              end
`ifdef PROC_CTRL_MVNZ_EN
              OP_MVNZ: begin
                if (Gnz) begin
                  Rout = y_sel;
                  Rin  = x_sel;
                end
              end
`endif
              default: ;
            endcase
          end
        end

        S_T2: begin
          Rout       = y_sel;
          Gin        = 1'b1;
          AddSub     = (ir_op == OP_SUB);
          state_next = S_T3;
        end

        S_T3: begin
          Gout       = 1'b1;
          Rin        = x_sel;
          Done       = 1'b1;
          state_next = S_T0;
        end

        default: state_next = S_T0;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_ctrl.sv
// tb_proc_ctrl: table-driven per-cycle check of proc_ctrl outputs, plus
// latency sequences with Run held high and a per-cycle bus-source check.

`ifndef REG_NUM
`define REG_NUM 4
`endif
`ifndef CMD_LENGTH
`define CMD_LENGTH 9
`endif

module tb_proc_ctrl;

  logic                   clk;
  logic                   rst;
  logic                   run;
  logic [`CMD_LENGTH-1:0] din;
  logic                   gnz;
  logic [`REG_NUM-1:0]    rout;
  logic                   gout;
  logic                   dinout;
  logic [`REG_NUM-1:0]    rin;
  logic                   ain;
  logic                   gin;
  logic                   addsub;
  logic                   done;

  int errors = 0;
  int checks = 0;

  proc_ctrl dut (
    .Clock  (clk),
    .Reset  (rst),
    .Run    (run),
    .DIN    (din),
    .Gnz    (gnz),
    .Rout   (rout),
    .Gout   (gout),
    .DINout (dinout),
    .Rin    (rin),
    .Ain    (ain),
    .Gin    (gin),
    .AddSub (addsub),
    .Done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed output view: {Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done}
  typedef struct {
    logic        rst;
    logic        run;
    logic        gnz;
    logic [8:0]  din;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [13:0] e(input logic [3:0] ro, input logic go,
                                    input logic dio, input logic [3:0] ri,
                                    input logic a, input logic g,
                                    input logic s, input logic d);
    return {ro, go, dio, ri, a, g, s, d};
  endfunction

  function automatic void add_vec(input logic r, input logic rn, input logic gz,
                                  input logic [8:0] d, input logic [13:0] x);
    vec_t v;
    v.rst = r; v.run = rn; v.gnz = gz; v.din = d; v.exp = x;
    vecs.push_back(v);
  endfunction

  // At most one bus source every cycle.
  always @(negedge clk) begin
    checks = checks + 1;
    if ($countones({rout, gout, dinout}) > 1) begin
      errors = errors + 1;
      $display("FAIL bus_onehot t=%0t actual rout=%b gout=%b dinout=%b required at most one set",
               $time, rout, gout, dinout);
    end
  end

  task automatic measure(input logic [8:0] d, input int exp_lat, input string nm);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    run = 1'b1;
    din = d;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    checks = checks + 1;
    if (lat != exp_lat) begin
      errors = errors + 1;
      $display("FAIL latency_%s actual=%0d required=%0d (0 = no Done within bound)", nm, lat, exp_lat);
    end else begin
      $display("seq %s latency=%0d", nm, lat);
    end
  endtask

  logic [13:0] act;
  logic [13:0] z;
  logic [13:0] mvnz_exp;

  initial begin
    z   = '0;
    rst = 1'b1;
    run = 1'b0;
    din = '0;
    gnz = 1'b0;

`ifdef PROC_CTRL_MVNZ_EN
    mvnz_exp = e(4'b0001, 0, 0, 4'b0010, 0, 0, 0, 1);
`else
    mvnz_exp = e(4'b0000, 0, 0, 4'b0000, 0, 0, 0, 1);
`endif

    //       rst run gnz din            expected outputs this cycle
    add_vec(1, 0, 0, 9'b000_000_000, z);                                   // reset
    add_vec(1, 1, 0, 9'b000_001_010, z);                                   // reset overrides Run
    add_vec(0, 0, 0, 9'b000_000_000, z);                                   // first cycle after reset
    add_vec(0, 1, 0, 9'b000_001_010, z);                                   // T0 fetch mv R1,R2
    add_vec(0, 0, 0, 9'b111_111_111, e(4'b0010, 0, 0, 4'b0100, 0, 0, 0, 1)); // T1 mv
    add_vec(0, 1, 0, 9'b001_011_000, z);                                   // T0 fetch mvi R3
    add_vec(0, 0, 0, 9'h005,         e(4'b0000, 0, 1, 4'b0001, 0, 0, 0, 1)); // T1 mvi
    add_vec(0, 1, 0, 9'b011_000_001, z);                                   // T0 fetch sub R0,R1
    add_vec(0, 0, 0, 9'b000_000_000, e(4'b1000, 0, 0, 4'b0000, 1, 0, 0, 0)); // T1 sub
    add_vec(0, 1, 0, 9'b000_101_000, e(4'b0100, 0, 0, 4'b0000, 0, 1, 1, 0)); // T2 sub, Run ignored
    add_vec(0, 1, 0, 9'b000_101_000, e(4'b0000, 1, 0, 4'b1000, 0, 0, 0, 1)); // T3 sub
    add_vec(0, 1, 0, 9'b000_101_000, z);                                   // T0 fetch X=5
    add_vec(0, 1, 0, 9'b100_010_011, e(4'b0000, 0, 0, 4'b0000, 0, 0, 0, 1)); // T1 illegal reg
    add_vec(0, 1, 0, 9'b100_010_011, z);                                   // T0 fetch op 100
    add_vec(0, 0, 0, 9'b000_000_000, e(4'b0000, 0, 0, 4'b0000, 0, 0, 0, 1)); // T1 op100 Gnz=0
    add_vec(0, 1, 0, 9'b100_010_011, z);                                   // T0 fetch op 100
    add_vec(0, 0, 1, 9'b000_000_000, mvnz_exp);                            // T1 op100 Gnz=1
    add_vec(0, 1, 0, 9'b010_011_011, z);                                   // T0 fetch add R3,R3
    add_vec(0, 0, 0, 9'b000_000_000, e(4'b0001, 0, 0, 4'b0000, 1, 0, 0, 0)); // T1 add
    add_vec(0, 0, 0, 9'b000_000_000, e(4'b0001, 0, 0, 4'b0000, 0, 1, 0, 0)); // T2 add
    add_vec(0, 0, 0, 9'b000_000_000, e(4'b0000, 1, 0, 4'b0001, 0, 0, 0, 1)); // T3 add
    add_vec(0, 1, 0, 9'b010_001_000, z);                                   // T0 fetch add R1,R0
    add_vec(0, 0, 0, 9'b000_000_000, e(4'b0100, 0, 0, 4'b0000, 1, 0, 0, 0)); // T1 add
    add_vec(1, 0, 0, 9'b000_000_000, z);                                   // reset during T2
    add_vec(0, 0, 0, 9'b000_000_000, z);                                   // T0 after abort
    add_vec(0, 0, 0, 9'b000_000_000, z);                                   // no late Done
    add_vec(0, 1, 0, 9'b000_000_011, z);                                   // T0 fetch mv R0,R3
    add_vec(0, 0, 0, 9'b000_000_000, e(4'b0001, 0, 0, 4'b1000, 0, 0, 0, 1)); // T1 mv
    add_vec(0, 1, 0, 9'b111_000_000, z);                                   // T0 fetch op 111
    add_vec(0, 0, 0, 9'b000_000_000, e(4'b0000, 0, 0, 4'b0000, 0, 0, 0, 1)); // T1 illegal op
    add_vec(0, 1, 0, 9'b000_001_110, z);                                   // T0 fetch Y=6
    add_vec(0, 0, 0, 9'b000_000_000, e(4'b0000, 0, 0, 4'b0000, 0, 0, 0, 1)); // T1 illegal Y
    add_vec(0, 0, 0, 9'b000_000_000, z);                                   // idle T0

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst = vecs[i].rst;
      run = vecs[i].run;
      gnz = vecs[i].gnz;
      din = vecs[i].din;
      @(negedge clk);
      act = {rout, gout, dinout, rin, ain, gin, addsub, done};
      checks = checks + 1;
      if (act !== vecs[i].exp) begin
        errors = errors + 1;
        $display("FAIL vec%0d actual=%b required=%b  {rout,gout,dinout,rin,ain,gin,addsub,done}",
                 i, act, vecs[i].exp);
      end else begin
        $display("vec%0d rst=%b run=%b din=%b outs=%b", i, vecs[i].rst, vecs[i].run,
                 vecs[i].din, act);
      end
    end

    // Run held high: back-to-back instructions, each fetched right after Done.
    measure(9'b000_010_001, 2, "mv");
    measure(9'b011_001_010, 4, "sub");
    measure(9'b001_000_000, 2, "mvi");
    @(posedge clk); #1;
    run = 1'b0;
    @(negedge clk);
    act = {rout, gout, dinout, rin, ain, gin, addsub, done};
    checks = checks + 1;
    if (act !== z) begin
      errors = errors + 1;
      $display("FAIL idle_after_seq actual=%b required=%b", act, z);
    end
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
